// File: rtl/alu4_result_stage.sv
// ============================================================================
// Module   : alu4_result_stage
// Purpose  : Assembles 4-bit ALU result beats into a word with flags and carry
//            feedback. Define ALU4_RS_SIGNEXT_EN to sign-extend unwritten
//            upper nibbles; otherwise they are zero-filled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu4_result_stage #(
  parameter int MAX_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [3:0]               alu_out,
  input  logic                     alu_mc,
  input  logic                     alu_rc,
  input  logic                     alu_ov,
  input  logic                     alu_zero,
  input  logic                     abort,
  input  logic                     clr_carry,
  output logic                     mc_fb,
  output logic                     rc_fb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*MAX_NIBBLES-1:0] out_data,
  output logic [3:0]               out_count,
  output logic [3:0]               out_flags
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COLLECT = 2'd1;
  localparam logic [1:0] c_HOLD    = 2'd2;
  localparam logic [3:0] c_LAST    = 4'(MAX_NIBBLES - 1);

  logic [1:0]               r_state;
  logic [3:0]               r_cnt;
  logic [4*MAX_NIBBLES-1:0] r_data;
  logic                     r_mc;
  logic                     r_rc;
  logic                     r_ov;
  logic                     r_zacc;

  logic                     w_open;
  logic                     w_acc;
  logic                     w_final;
  logic [3:0]               w_fill;
  logic [4*MAX_NIBBLES-1:0] w_word;

  assign w_open   = ena && (r_state != c_HOLD);
  assign in_ready = w_open;
  // Abort takes priority over a beat presented in the same cycle.
  assign w_acc    = w_open && in_valid && !abort;
  assign w_final  = in_last || (r_cnt == c_LAST);

`ifdef ALU4_RS_SIGNEXT_EN
  assign w_fill = {4{alu_out[3]}};
`else
  assign w_fill = 4'h0;
`endif

  // A new word starts from a clean slate so stale nibbles never leak through.
  always_comb begin
    w_word = (r_state == c_IDLE) ? '0 : r_data;
    for (int i = 0; i < MAX_NIBBLES; i++) begin
      if (4'(i) == r_cnt) begin
        w_word[i*4 +: 4] = alu_out;
      end else if (4'(i) > r_cnt) begin
        w_word[i*4 +: 4] = w_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
      r_data  <= '0;
      r_mc    <= 1'b0;
      r_rc    <= 1'b0;
      r_ov    <= 1'b0;
      r_zacc  <= 1'b0;
    end else if (ena) begin
      if (r_state == c_HOLD) begin
        if (out_ready) begin
          r_state <= c_IDLE;
          r_cnt   <= 4'd0;
        end
      end else if (abort) begin
        r_state <= c_IDLE;
        r_cnt   <= 4'd0;
      end else if (w_acc) begin
        r_data  <= w_word;
        r_cnt   <= r_cnt + 4'd1;
        r_ov    <= alu_ov;
        r_zacc  <= (r_state == c_IDLE) ? alu_zero : (r_zacc & alu_zero);
        r_state <= w_final ? c_HOLD : c_COLLECT;
      end

      // Carries persist across words for chaining; a beat's flags beat a clear.
      if (w_acc) begin
        r_mc <= alu_mc;
        r_rc <= alu_rc;
      end else if (clr_carry) begin
        r_mc <= 1'b0;
        r_rc <= 1'b0;
      end
    end
  end

  assign out_valid = (r_state == c_HOLD);
  assign out_data  = r_data;
  assign out_count = r_cnt;
  assign out_flags = {r_ov, r_zacc, r_rc, r_mc};
  assign mc_fb     = r_mc;
  assign rc_fb     = r_rc;

endmodule

`default_nettype wire

// File: tb/tb_alu4_result_stage.sv
// ============================================================================
// Module   : tb_alu4_result_stage
// Purpose  : Scoreboard bench for alu4_result_stage with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu4_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  alu_out = 4'h0;
  logic        alu_mc = 1'b0;
  logic        alu_rc = 1'b0;
  logic        alu_ov = 1'b0;
  logic        alu_zero = 1'b0;
  logic        abort = 1'b0;
  logic        clr_carry = 1'b0;
  logic        mc_fb;
  logic        rc_fb;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_count;
  logic [3:0]  out_flags;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  c;
    logic [3:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef ALU4_RS_SIGNEXT_EN
  localparam logic [15:0] c_SHORT = 16'hFF8A;
`else
  localparam logic [15:0] c_SHORT = 16'h008A;
`endif

  alu4_result_stage #(.MAX_NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .alu_out   (alu_out),
    .alu_mc    (alu_mc),
    .alu_rc    (alu_rc),
    .alu_ov    (alu_ov),
    .alu_zero  (alu_zero),
    .abort     (abort),
    .clr_carry (clr_carry),
    .mc_fb     (mc_fb),
    .rc_fb     (rc_fb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is scored against the queue.
  always @(negedge clk) begin
    if (rst_n && ena && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got data 0x%0h with nothing expected", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data",  32'(out_data),  32'(e.d));
        chk("word_count", 32'(out_count), 32'(e.c));
        chk("word_flags", 32'(out_flags), 32'(e.f));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] d, input logic last, input logic z,
                      input logic mc, input logic rc, input logic ov);
    in_valid = 1'b1; alu_out = d; in_last = last;
    alu_zero = z; alu_mc = mc; alu_rc = rc; alu_ov = ov;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    alu_zero = 1'b0; alu_mc = 1'b0; alu_rc = 1'b0; alu_ov = 1'b0;
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [3:0] c, input logic [3:0] f);
    exp_t e;
    e.d = d; e.c = c; e.f = f;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-COLLECT discards the word and carries
    beat(4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    beat(4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_rst_mc_fb", 32'(mc_fb), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_mc_fb",     32'(mc_fb), 0);
    chk("async_rst_rc_fb",     32'(rc_fb), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Full word with in_last on the 4th beat
    expect_word(16'h4321, 4'd4, 4'b0000);
    beat(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;

    // Full word closed by the nibble count alone
    expect_word(16'h1765, 4'd4, 4'b0000);
    beat(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Short word: fill of unwritten nibbles
    expect_word(c_SHORT, 4'd2, 4'b0000);
    beat(4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Backpressure with a beat waiting
    out_ready = 1'b0;
    expect_word(16'h0021, 4'd2, 4'b0000);
    beat(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; alu_out = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data",  32'(out_data),  32'h0021);
      chk("bp_out_count", 32'(out_count), 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_after_out_valid", 32'(out_valid), 0);
    chk("bp_after_in_ready",  32'(in_ready),  1);
    @(posedge clk); #1;

    // Zero-flag accumulation
    expect_word(16'h0000, 4'd3, 4'b0100);
    beat(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_word(16'h0543, 4'd3, 4'b1011);
    beat(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat(4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk("chain_out_valid", 32'(out_valid), 0);
    chk("chain_mc_fb",     32'(mc_fb), 1);
    chk("chain_rc_fb",     32'(rc_fb), 1);
    @(posedge clk); #1;
    clr_carry = 1'b1;
    tick();
    clr_carry = 1'b0;
    @(negedge clk);
    chk("clr_mc_fb", 32'(mc_fb), 0);
    chk("clr_rc_fb", 32'(rc_fb), 0);
    @(posedge clk); #1;

    // Carry clear collides with a beat: the beat wins
    clr_carry = 1'b1;
    beat(4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_carry = 1'b0;
    @(negedge clk);
    chk("clr_vs_beat_mc_fb", 32'(mc_fb), 1);
    @(posedge clk); #1;

    // Abort discards the open word and the same-cycle beat
    in_valid = 1'b1; alu_out = 4'hE; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    beat(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat(4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_word(16'h0005, 4'd1, 4'b0000);
    beat(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Abort in HOLD is ignored
    out_ready = 1'b0;
    expect_word(16'h0003, 4'd1, 4'b0000);
    beat(4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("hold_abort_out_valid", 32'(out_valid), 1);
    chk("hold_abort_out_data",  32'(out_data),  32'h0003);
    @(posedge clk); #1;

    // ena low freezes the stage: no handshake, no beat
    ena = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("freeze_out_valid", 32'(out_valid), 1);
    chk("freeze_in_ready",  32'(in_ready),  0);
    @(posedge clk); #1;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    in_valid = 1'b1; alu_out = 4'h6; in_last = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("freeze_no_beat", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    ena = 1'b1;

    // Drain the scoreboard within a bounded window
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
